// File: rtl/wi23_defs.sv
// wi23_defs: shared instruction-memory geometry and the loader state encoding.
package wi23_defs;

    localparam int IMEM_DEPTH = 8;
    localparam int IMEM_WIDTH = 32;
    localparam int IMEM_BYTES = IMEM_WIDTH / 8;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_WRITE,
        LD_DONE,
        LD_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it word by word into imem while holding the core.
module imem_loader
    import wi23_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  we_o,
    output logic [IMEM_DEPTH-1:0] waddr_o,
    output logic [IMEM_WIDTH-1:0] wdata_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [TW-1:0]       T_ONE = 1;
    localparam logic [BW-1:0]       B_ONE = 1;
    localparam logic [IMEM_DEPTH:0] W_ONE = 1;

    loader_state_e          state_q, state_d;
    logic [15:0]            n_q;
    logic [IMEM_DEPTH:0]    wcnt_q;
    logic [BW-1:0]          bcnt_q;
    logic [TW-1:0]          tcnt_q;
    logic [IMEM_WIDTH-1:0]  word_q, asm;
    logic [IMEM_DEPTH-1:0]  waddr_q;
    logic [IMEM_WIDTH-1:0]  wdata_q;
    logic                   acc, restart, last_byte, timeout, too_big, all_written;
    logic [15:0]            len_full;
    logic [IMEM_DEPTH:0]    wcnt_inc;

    assign rx_ready_o  = state_q == LD_LEN_LO || state_q == LD_LEN_HI || state_q == LD_DATA;
    assign cpu_hold_o  = !(state_q == LD_IDLE || state_q == LD_DONE || state_q == LD_ERR);
    assign we_o        = state_q == LD_WRITE;
    assign done_o      = state_q == LD_DONE;
    assign err_o       = state_q == LD_ERR;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;

    assign acc         = rx_valid_i && rx_ready_o;
    assign restart     = start_i && !cpu_hold_o;
    assign last_byte   = bcnt_q == BW'(IMEM_BYTES - 1);
    assign timeout     = !acc && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign len_full    = {rx_data_i, n_q[7:0]};
    assign too_big     = 32'(len_full) > (32'd1 << IMEM_DEPTH);
    assign wcnt_inc    = wcnt_q + W_ONE;
    assign all_written = 32'(wcnt_inc) == 32'(n_q);

    // Drop the incoming byte into its lane of the word being assembled.
    always_comb begin
        asm = word_q;
        asm[8*bcnt_q +: 8] = rx_data_i;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= LD_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a stalled stream in any receiving state ends in ERR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: state_d = restart ? LD_LEN_LO : state_q;
            LD_LEN_LO: state_d = timeout ? LD_ERR : acc ? LD_LEN_HI : state_q;
            LD_LEN_HI: state_d = timeout ? LD_ERR : !acc ? state_q :
                                 len_full == 16'd0 ? LD_DONE : too_big ? LD_ERR : LD_DATA;
            LD_DATA:   state_d = timeout ? LD_ERR : (acc && last_byte) ? LD_WRITE : state_q;
            LD_WRITE:  state_d = all_written ? LD_DONE : LD_DATA;
            default:   state_d = LD_IDLE;
        endcase
    end

    // Length, word assembly, write port registers and the byte-gap timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q     <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            word_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (state_q == LD_IDLE || restart) begin
                n_q    <= '0;
                wcnt_q <= '0;
                bcnt_q <= '0;
                tcnt_q <= '0;
            end else if (rx_ready_o) begin
                tcnt_q <= acc ? '0 : tcnt_q + T_ONE;
            end
            if (acc && state_q == LD_LEN_LO) n_q[7:0]  <= rx_data_i;
            if (acc && state_q == LD_LEN_HI) n_q[15:8] <= rx_data_i;
            if (acc && state_q == LD_DATA) begin
                word_q <= asm;
                bcnt_q <= last_byte ? '0 : bcnt_q + B_ONE;
                if (last_byte) begin
                    wdata_q <= asm;
                    waddr_q <= wcnt_q[IMEM_DEPTH-1:0];
                end
            end
            if (state_q == LD_WRITE) wcnt_q <= wcnt_inc;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized loads checked against a queue-based model of the expected writes.
module tb_imem_loader;
    import wi23_defs::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [7:0]            rx_data_i = '0;
    logic                  rx_valid_i = 1'b0;
    logic                  rx_ready_o, we_o, cpu_hold_o, done_o, err_o;
    logic [IMEM_DEPTH-1:0] waddr_o;
    logic [IMEM_WIDTH-1:0] wdata_o;

    imem_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rx_data_i(rx_data_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .we_o(we_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .cpu_hold_o(cpu_hold_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [IMEM_DEPTH-1:0] obs_a[$], exp_a[$];
    logic [IMEM_WIDTH-1:0] obs_d[$], exp_d[$];

    typedef struct {
        logic [15:0] len;
        int          nw;
        bit          done;
        bit          err;
        int          writes;
    } vec_t;

    // Record every write strobe seen by the memory.
    always @(negedge clk) begin
        if (we_o) begin
            obs_a.push_back(waddr_o);
            obs_d.push_back(wdata_o);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic compare_writes(input string name);
        chk({name, "_count"}, 64'(obs_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), 64'(obs_a[i]), 64'(exp_a[i]));
            chk($sformatf("%s_data%0d", name, i), 64'(obs_d[i]), 64'(exp_d[i]));
        end
        clear_q();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w = 0;
        if (gap > 0) begin
            rx_valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rx_ready_o) begin
            total++;
            bad++;
            $display("FAIL rx_ready_wait: got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] len, input int nw, input int gmax, input bit poke);
        logic [IMEM_WIDTH-1:0] w;
        pulse_start();
        send_byte(len[7:0], $urandom_range(gmax, 0));
        send_byte(len[15:8], $urandom_range(gmax, 0));
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            exp_a.push_back(IMEM_DEPTH'(i));
            exp_d.push_back(w);
            for (int b = 0; b < IMEM_BYTES; b++) begin
                start_i = poke && b == 1;
                send_byte(w[8*b +: 8], $urandom_range(gmax, 0));
                start_i = 1'b0;
            end
        end
        rx_valid_i = 1'b0;
    endtask

    initial begin
        vec_t vt[5];
        logic [IMEM_WIDTH-1:0] words[3];
        logic [IMEM_WIDTH-1:0] w;
        int cnt;
        vt[0] = '{16'd0,      0, 1'b1, 1'b0, 0};
        vt[1] = '{16'd1,      1, 1'b1, 1'b0, 1};
        vt[2] = '{16'd3,      3, 1'b1, 1'b0, 3};
        vt[3] = '{16'd257,    0, 1'b0, 1'b1, 0};
        vt[4] = '{16'hFFFF,   0, 1'b0, 1'b1, 0};
        words[0] = 32'h11223344;
        words[1] = 32'hDEADBEEF;
        words[2] = 32'h00000001;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({we_o, rx_ready_o, cpu_hold_o, done_o, err_o, waddr_o, wdata_o}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 64'({we_o, rx_ready_o, cpu_hold_o, done_o, err_o}), 64'd0);

        for (int i = 0; i < 5; i++) begin
            clear_q();
            load(vt[i].len, vt[i].nw, 2, 1'b0);
            if (vt[i].nw == 0)
                chk($sformatf("vec%0d_flags_after_len", i), 64'({done_o, err_o}), 64'({vt[i].done, vt[i].err}));
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_flags", i), 64'({done_o, err_o, cpu_hold_o}), 64'({vt[i].done, vt[i].err, 1'b0}));
            chk($sformatf("vec%0d_writes", i), 64'(obs_a.size()), 64'(vt[i].writes));
            compare_writes($sformatf("vec%0d", i));
        end

        clear_q();
        pulse_start();
        chk("b2b_hold_ready", 64'({cpu_hold_o, rx_ready_o}), 64'b11);
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            w = words[i];
            exp_a.push_back(IMEM_DEPTH'(i));
            exp_d.push_back(w);
            for (int b = 0; b < IMEM_BYTES; b++) begin
                send_byte(w[8*b +: 8], 0);
                if (b < IMEM_BYTES - 1) chk($sformatf("b2b_no_we_w%0d_b%0d", i, b), 64'(we_o), 64'd0);
            end
            chk($sformatf("b2b_we_w%0d", i), 64'(we_o), 64'd1);
            chk($sformatf("b2b_ready_low_w%0d", i), 64'(rx_ready_o), 64'd0);
            chk($sformatf("b2b_waddr_w%0d", i), 64'(waddr_o), 64'(i));
            chk($sformatf("b2b_wdata_w%0d", i), 64'(wdata_o), 64'(w));
        end
        rx_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_end", 64'({cpu_hold_o, done_o, we_o}), 64'b010);
        compare_writes("b2b");

        clear_q();
        pulse_start();
        send_byte(8'd1, 0);
        send_byte(8'd0, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rx_valid_i = 1'b0;
        cnt = 0;
        while (!err_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles", 64'(cnt), 64'd16);
        chk("timeout_flags", 64'({err_o, done_o, cpu_hold_o}), 64'b100);
        chk("timeout_no_we", 64'(obs_a.size()), 64'd0);

        clear_q();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        rx_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_outputs", 64'({we_o, rx_ready_o, cpu_hold_o, done_o, err_o, waddr_o, wdata_o}), 64'd0);
        @(negedge clk);
        chk("midreset_no_we_after", 64'(we_o), 64'd0);
        chk("midreset_no_writes", 64'(obs_a.size()), 64'd0);
        clear_q();
        load(16'd2, 2, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("midreset_reload_done", 64'({done_o, err_o}), 64'b10);
        compare_writes("midreset_reload");

        for (int it = 0; it < 8; it++) begin
            int len;
            len = $urandom_range(6, 1);
            clear_q();
            load(16'(len), len, 4, it[0]);
            repeat (2) @(negedge clk);
            chk($sformatf("rand%0d_flags", it), 64'({done_o, err_o, cpu_hold_o}), 64'b100);
            compare_writes($sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: max clk cycles allowed between accepted bytes once a load has begun.
REQ-002 SHALL have clk, input, 1: sole clock; all state updates on posedge.
REQ-003 SHALL have rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have start_i, input, 1: one-cycle pulse that begins a load.
REQ-005 SHALL have rx_data_i, input, 8: incoming program byte.
REQ-006 SHALL have rx_valid_i, input, 1: rx_data_i valid; byte accepted when rx_valid_i && rx_ready_o.
REQ-007 SHALL have rx_ready_o, output, 1: loader can accept a byte this cycle.
REQ-008 SHALL have we_o, output, 1: imem write strobe, one cycle per word.
REQ-009 SHALL have waddr_o, output, IMEM_DEPTH: word address for the write.
REQ-010 SHALL have wdata_o, output, IMEM_WIDTH: word data for the write.
REQ-011 SHALL have cpu_hold_o, output, 1: holds the core in reset while a load is in progress.
REQ-012 SHALL have done_o, output, 1: sticky; load completed successfully.
REQ-013 SHALL have err_o, output, 1: sticky; load aborted on length overflow or timeout.

Function
REQ-014 SHALL accept stream format: 2-byte word count N (low byte first), then N words, each IMEM_WIDTH/8 bytes, least-significant byte first.
REQ-015 SHALL implement FSM states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-016 IDLE: rx_ready_o=0; start_i -> LEN_LO; clear done_o/err_o; zero address and byte counters and timeout counter.
REQ-017 LEN_LO/LEN_HI: each accepted byte stored into N; after LEN_HI, N=0 -> DONE; N > 2^IMEM_DEPTH -> ERR; otherwise -> DATA.
REQ-018 DATA: accepted bytes shift into word register at byte lane = byte counter; after last byte of a word -> WRITE.
REQ-019 WRITE: rx_ready_o=0; we_o=1 for exactly one cycle with waddr_o=word counter, wdata_o=assembled word; then increment word counter; if counter reaches N -> DONE, else -> DATA.
REQ-020 Latency from acceptance of a word's final byte to we_o high SHALL be exactly 1 cycle.
REQ-021 rx_ready_o SHALL be 1 only in LEN_LO, LEN_HI, DATA.
REQ-022 cpu_hold_o SHALL be 1 in every state except IDLE, DONE, ERR.
REQ-023 DONE: done_o=1; ERR: err_o=1; both states return to LEN_LO on start_i (treated as a restart from IDLE).
REQ-024 Timeout counter SHALL reset on every accepted byte and count in LEN_LO/LEN_HI/DATA; reaching TIMEOUT_CYCLES -> ERR, no further writes.
REQ-025 start_i while cpu_hold_o=1 SHALL be ignored.
REQ-026 Word counter width SHALL be IMEM_DEPTH+1 so N = 2^IMEM_DEPTH completes without wrap; waddr_o = low IMEM_DEPTH bits.
REQ-027 we_o SHALL never assert outside WRITE; waddr_o/wdata_o hold last values when we_o=0.

Reset
REQ-028 rst_n=0 at posedge SHALL force IDLE, we_o=0, rx_ready_o=0, cpu_hold_o=0, done_o=0, err_o=0, waddr_o=0, wdata_o=0, all counters 0.
REQ-029 Reset mid-load SHALL abort immediately; no write is issued in the cycle after reset deasserts.

Structure
REQ-030 IMEM_DEPTH, IMEM_WIDTH SHALL come from wi23_defs; the loader state enum SHALL be added to wi23_defs.
REQ-031 Single module, no sub-modules; write port connects to an added write port on the instruction memory.

Verification
REQ-032 Load N=3 words 0x11223344, 0xDEADBEEF, 0x00000001 (IMEM_WIDTH=32), back-to-back bytes -> three we_o pulses at addr 0,1,2 with those data; done_o=1; cpu_hold_o falls the cycle after the last write.
REQ-033 N=0 (bytes 0x00,0x00) -> no we_o; done_o=1 after second byte.
REQ-034 N exceeding 2^IMEM_DEPTH -> err_o=1 after LEN_HI byte; no we_o ever.
REQ-035 Stop sending after 2 data bytes, TIMEOUT_CYCLES=16 -> err_o=1 16 cycles after last accepted byte; no we_o.
REQ-036 rx_valid_i held high continuously -> rx_ready_o low during each WRITE cycle; no byte lost or duplicated; data match.
REQ-037 rst_n low for 1 cycle mid-word, then new start_i and full load -> only new-load writes occur, starting at addr 0.
